// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: four-channel arbiter in front of one shared 32-bit binary to
// 10-digit BCD converter. A request is granted in IDLE, its operand is
// converted during CONV, and the registered result is presented in DONE.
//
// Build option: define BCD_CONV_ARB_RR_EN for round-robin arbitration;
// without it, channel 0 has fixed highest priority.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and operand capture on exit
// CONV  | operand held, grant pulse visible, converter evaluating
// DONE  | result registered, VLD_o high
module bcd_conv_arb (
    input  logic         CK_i,
    input  logic         XARST_i,
    input  logic         EN_CK_i,
    input  logic [3:0]   REQ_i,
    input  logic [127:0] DAT_i,
    output logic [3:0]   GNT_o,
    output logic         BUSY_o,
    output logic         VLD_o,
    output logic [1:0]   CH_o,
    output logic [39:0]  QQ_o,
    output logic [3:0]   ND_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        do_grant;
    logic [1:0]  win;
    logic [31:0] operand;
    logic [1:0]  ch_q;
    logic [39:0] qq_q;
    logic [39:0] bcd_comb;

    // Shift-and-add-3 over all 32 bits, fully unrolled into one combinational
    // stage; the 40-bit result cannot overflow for any 32-bit operand.
    function automatic logic [39:0] bin2bcd(input logic [31:0] bin);
        logic [39:0] bcd;
        bcd = '0;
        for (int i = 31; i >= 0; i--) begin
            for (int d = 0; d < 10; d++) begin
                if (bcd[4*d +: 4] >= 4'd5)
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[38:0], bin[i]};
        end
        return bcd;
    endfunction

    assign do_grant = (state == ST_IDLE) && (REQ_i != 4'b0000);

`ifdef BCD_CONV_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_idx;
    logic       rr_hit;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        win    = 2'd0;
        rr_hit = 1'b0;
        rr_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = rr_ptr + 2'(k);
            if (!rr_hit && REQ_i[rr_idx]) begin
                win    = rr_idx;
                rr_hit = 1'b1;
            end
        end
    end

    // Pointer remembers the last winner; reset value 3 makes channel 0 first
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i)
            rr_ptr <= 2'd3;
        else if (EN_CK_i && do_grant)
            rr_ptr <= win;
    end
`else
    // Fixed priority, channel 0 highest
    always_comb begin
        win = 2'd0;
        if (REQ_i[3]) win = 2'd3;
        if (REQ_i[2]) win = 2'd2;
        if (REQ_i[1]) win = 2'd1;
        if (REQ_i[0]) win = 2'd0;
    end
`endif

    assign bcd_comb = bin2bcd(operand);

    // FSM state register
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i)
            state <= ST_IDLE;
        else if (EN_CK_i)
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (REQ_i != 4'b0000) state_nxt = ST_CONV;
            ST_CONV: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; the grant is decoded from the captured channel so it
    // stretches with the state when the clock enable is low
    always_comb begin
        GNT_o  = 4'b0000;
        BUSY_o = 1'b0;
        VLD_o  = 1'b0;
        case (state)
            ST_CONV: begin
                GNT_o  = 4'b0001 << ch_q;
                BUSY_o = 1'b1;
            end
            ST_DONE: begin
                BUSY_o = 1'b1;
                VLD_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand and channel capture at grant; result register loads leaving CONV
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            operand <= '0;
            ch_q    <= '0;
            qq_q    <= '0;
        end else if (EN_CK_i) begin
            if (do_grant) begin
                operand <= DAT_i[{win, 5'b00000} +: 32];
                ch_q    <= win;
            end
            if (state == ST_CONV)
                qq_q <= bcd_comb;
        end
    end

    // Significant digit count: highest nonzero digit index + 1, minimum 1
    always_comb begin
        ND_o = 4'd1;
        for (int d = 0; d < 10; d++) begin
            if (qq_q[4*d +: 4] != 4'd0)
                ND_o = 4'(d + 1);
        end
    end

    assign CH_o = ch_q;
    assign QQ_o = qq_q;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// tb_bcd_conv_arb: directed vector table plus hand sequences for arbitration,
// clock-enable stall, mid-conversion reset and a random operand sweep.
module tb_bcd_conv_arb;

    logic         CK_i;
    logic         XARST_i;
    logic         EN_CK_i;
    logic [3:0]   REQ_i;
    logic [127:0] DAT_i;
    logic [3:0]   GNT_o;
    logic         BUSY_o;
    logic         VLD_o;
    logic [1:0]   CH_o;
    logic [39:0]  QQ_o;
    logic [3:0]   ND_o;

    int checks   = 0;
    int failures = 0;

    bcd_conv_arb dut (
        .CK_i    (CK_i),
        .XARST_i (XARST_i),
        .EN_CK_i (EN_CK_i),
        .REQ_i   (REQ_i),
        .DAT_i   (DAT_i),
        .GNT_o   (GNT_o),
        .BUSY_o  (BUSY_o),
        .VLD_o   (VLD_o),
        .CH_o    (CH_o),
        .QQ_o    (QQ_o),
        .ND_o    (ND_o)
    );

    initial CK_i = 1'b0;
    always #5 CK_i = ~CK_i;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] dat;
        logic [39:0] qq;
        logic [3:0]  nd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference conversion by repeated division, independent of shift-add-3
    function automatic logic [39:0] model_bcd(input logic [31:0] v);
        logic [39:0]     r;
        longint unsigned x;
        r = '0;
        x = longint'(v);
        for (int d = 0; d < 10; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_nd(input logic [31:0] v);
        logic [3:0]      n;
        longint unsigned x;
        n = 4'd1;
        x = longint'(v) / 10;
        while (x != 0) begin
            n++;
            x = x / 10;
        end
        return n;
    endfunction

    task automatic apply_reset();
        @(negedge CK_i);
        XARST_i = 1'b0;
        REQ_i   = 4'b0000;
        @(negedge CK_i);
        XARST_i = 1'b1;
    endtask

    // Waits (bounded) for any grant at a falling edge; returns found flag
    task automatic wait_grant(output logic found);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CK_i);
            if (GNT_o != 4'b0000) found = 1'b1;
        end
    endtask

    task automatic do_conv(input logic [1:0] ch, input logic [31:0] dat,
                           input logic [39:0] exp_qq, input logic [3:0] exp_nd,
                           input string nm);
        logic       found;
        logic [3:0] eg;
        eg = 4'b0001 << ch;
        REQ_i[ch] = 1'b1;
        DAT_i[32*ch +: 32] = dat;
        wait_grant(found);
        chk({nm, "_gnt"}, GNT_o, eg);
        REQ_i[ch] = 1'b0;
        if (!found) return;
        chk({nm, "_busy"}, BUSY_o, 1'b1);
        @(negedge CK_i);
        chk({nm, "_vld"}, VLD_o, 1'b1);
        chk({nm, "_gnt_off"}, GNT_o, 4'b0000);
        chk({nm, "_qq"}, QQ_o, exp_qq);
        chk({nm, "_nd"}, ND_o, exp_nd);
        chk({nm, "_ch"}, CH_o, ch);
        @(negedge CK_i);
        chk({nm, "_vld_off"}, VLD_o, 1'b0);
    endtask

    initial begin
        logic       found;
        logic       vld_seen;
        int         rr_exp[5];
        logic [3:0] eg;
        logic [1:0] rch;
        logic [31:0] rdat;

        vecs[0] = '{ch: 2'd0, dat: 32'd0,          qq: 40'h0000000000, nd: 4'd1};
        vecs[1] = '{ch: 2'd2, dat: 32'hFFFFFFFF,   qq: 40'h4294967295, nd: 4'd10};
        vecs[2] = '{ch: 2'd1, dat: 32'd1234567,    qq: 40'h0001234567, nd: 4'd7};
        vecs[3] = '{ch: 2'd3, dat: 32'd9,          qq: 40'h0000000009, nd: 4'd1};
        vecs[4] = '{ch: 2'd0, dat: 32'd10,         qq: 40'h0000000010, nd: 4'd2};
        vecs[5] = '{ch: 2'd1, dat: 32'd99999,      qq: 40'h0000099999, nd: 4'd5};
        vecs[6] = '{ch: 2'd2, dat: 32'd1000000000, qq: 40'h1000000000, nd: 4'd10};
        vecs[7] = '{ch: 2'd3, dat: 32'd4000000000, qq: 40'h4000000000, nd: 4'd10};

`ifdef BCD_CONV_ARB_RR_EN
        rr_exp = '{0, 1, 2, 3, 0};
`else
        rr_exp = '{0, 0, 0, 0, 0};
`endif

        XARST_i = 1'b0;
        EN_CK_i = 1'b1;
        REQ_i   = 4'b0000;
        DAT_i   = '0;
        #1;
        chk("rst_gnt", GNT_o, 4'b0000);
        chk("rst_busy", BUSY_o, 1'b0);
        chk("rst_vld", VLD_o, 1'b0);
        chk("rst_ch", CH_o, 2'd0);
        chk("rst_qq", QQ_o, 40'h0);
        chk("rst_nd", ND_o, 4'd1);
        @(negedge CK_i);
        @(negedge CK_i);
        XARST_i = 1'b1;

        // Directed table; first entry is the first request after reset
        for (int i = 0; i < 8; i++)
            do_conv(vecs[i].ch, vecs[i].dat, vecs[i].qq, vecs[i].nd, $sformatf("vec%0d", i));

        // Arbitration order with all requests held
        apply_reset();
        DAT_i = {32'd33, 32'd22, 32'd11, 32'd0};
        REQ_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(found);
            eg = 4'b0001 << rr_exp[i];
            chk($sformatf("arb_order%0d", i), GNT_o, eg);
            @(negedge CK_i);
        end
        REQ_i = 4'b0000;
        repeat (3) @(negedge CK_i);

        // Clock-enable stall during CONV
        REQ_i[1] = 1'b1;
        DAT_i[63:32] = 32'd1234567;
        wait_grant(found);
        chk("stall_gnt", GNT_o, 4'b0010);
        REQ_i[1] = 1'b0;
        EN_CK_i  = 1'b0;
        vld_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK_i);
            vld_seen = vld_seen | VLD_o;
            chk($sformatf("stall_hold_gnt%0d", i), GNT_o, 4'b0010);
        end
        chk("stall_no_vld", vld_seen, 1'b0);
        EN_CK_i = 1'b1;
        @(negedge CK_i);
        chk("stall_vld", VLD_o, 1'b1);
        chk("stall_qq", QQ_o, 40'h0001234567);
        chk("stall_nd", ND_o, 4'd7);
        chk("stall_ch", CH_o, 2'd1);
        @(negedge CK_i);
        chk("stall_vld_off", VLD_o, 1'b0);

        // Reset asserted mid-conversion aborts it
        REQ_i[3] = 1'b1;
        DAT_i[127:96] = 32'd777;
        wait_grant(found);
        chk("abort_gnt", GNT_o, 4'b1000);
        XARST_i = 1'b0;
        REQ_i   = 4'b0000;
        #1;
        chk("abort_gnt_clr", GNT_o, 4'b0000);
        chk("abort_busy", BUSY_o, 1'b0);
        chk("abort_vld", VLD_o, 1'b0);
        chk("abort_ch", CH_o, 2'd0);
        chk("abort_qq", QQ_o, 40'h0);
        @(negedge CK_i);
        XARST_i  = 1'b1;
        vld_seen = 1'b0;
        repeat (4) begin
            @(negedge CK_i);
            vld_seen = vld_seen | VLD_o;
        end
        chk("abort_never_vld", vld_seen, 1'b0);
        do_conv(2'd2, 32'd5, 40'h0000000005, 4'd1, "after_abort");

        // Random sweep against the division model
        for (int i = 0; i < 10000; i++) begin
            rch  = 2'($urandom_range(3));
            rdat = $urandom;
            do_conv(rch, rdat, model_bcd(rdat), model_nd(rdat), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
